prco_uart_tx: RTL and testbench
===============================

Name: prco_uart_tx

Overview:
- Downstream consumer of the core's UART output path.
- Accepts byte-wide transmit pulses from the core (byte taken from ALU result[7:0]), buffers them in a small FIFO, and serialises them as 8N1 frames on the tx pin.
- Replaces the generic uart_fifo transmit half.
- Exposes full/empty/busy so the core can stall its uart write when full, plus a sticky overflow flag for the debug port.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- i_clk  input  1  core clock
- i_reset_n  input  1  asynchronous active-low reset
- i_transmit  input  1  single-cycle push strobe from core
- i_tx_byte  input  8  byte to enqueue when i_transmit is high
- q_tx  output  1  serial line, idle high
- q_tx_fifo_full  output  1  FIFO holds 2**FIFO_AW entries
- q_tx_fifo_empty  output  1  FIFO holds 0 entries
- q_busy  output  1  serialiser not in IDLE, or FIFO non-empty
- q_count  output  FIFO_AW+1  current FIFO occupancy
- q_overflow  output  1  sticky: a push was dropped because FIFO was full

Behaviour:
- Reset (i_reset_n low, async):
  - q_tx=1, q_tx_fifo_full=0, q_tx_fifo_empty=1, q_busy=0, q_count=0, q_overflow=0.
  - FSM=IDLE, pointers=0, baud counter=0, bit index=0.
  - Reset asserted mid-frame aborts the frame immediately; q_tx returns high asynchronously.
  - FIFO contents are discarded.
- Push:
  - On a rising edge with i_transmit=1 and q_tx_fifo_full=0, i_tx_byte is written at the write pointer, which then increments modulo depth.
  - Full is evaluated before any same-cycle pop: push while full is dropped even if a pop occurs that cycle, and q_overflow is set.
  - q_overflow clears only on reset.
- Pop: performed only by the FSM, never externally.
- Occupancy:
  - q_count = pushes accepted − pops, kept in a FIFO_AW+1 bit counter.
  - Simultaneous accepted push and pop leaves q_count unchanged.
  - Full/empty are derived registered from q_count.
  - Pointers wrap at 2**FIFO_AW with no gap.
- FSM states IDLE, START, DATA, STOP; baud counter counts 0..CLK_DIV−1; q_tx is registered.
  - IDLE: q_tx=1. If FIFO non-empty: pop head into 8-bit shift register, clear baud counter, go to START.
  - START: q_tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: q_tx=shift[0], LSB first. Every CLK_DIV cycles shift right and increment bit index; after bit 7's period go to STOP.
  - STOP: q_tx=1 for CLK_DIV cycles. At the end, if FIFO non-empty, pop and go directly to START; otherwise go to IDLE.
- Latency: push accepted at edge N gives FIFO non-empty at N. The FSM pops at edge N+1, and q_tx falls at edge N+2.
- Frame length: exactly 10*CLK_DIV cycles. Back-to-back frames have no extra idle cycles beyond the stop bit.
- q_busy = (state != IDLE) | !q_tx_fifo_empty, registered in step with state.
- A push arriving while the serialiser is mid-frame never disturbs the frame in flight.
- Baud counter width: clog2(CLK_DIV) bits; it rolls over only at CLK_DIV−1.

Decomposition:
- Shared constants in inc/prco_constants.v:
  - UART state encodings UART_TX_IDLE/START/DATA/STOP (2 bits).
  - Default CLK_DIV value PRCO_UART_DIV_115200.
- One sub-module: prco_sync_fifo, a parameterised synchronous FIFO with push/pop/count/full/empty and async active-low reset.
- prco_uart_tx holds the FSM, baud counter, shift register and overflow flag.

Test Plan (CLK_DIV=4, FIFO_AW=2 unless stated):
- Reset and idle:
  - Stimulus: hold i_reset_n low 3 cycles, release, no pushes for 50 cycles.
  - Response: q_tx=1, q_tx_fifo_empty=1, q_busy=0, q_count=0 throughout.
- Single byte:
  - Stimulus: push 8'hA5 at edge N.
  - Response: q_tx low from N+2 for 4 cycles, then data bits 1,0,1,0,0,1,0,1 (4 cycles each), then high. q_busy falls at N+42; q_count returns to 0 at N+1.
- Fill and overflow:
  - Stimulus: push 8'h01..8'h06 on 6 consecutive cycles.
  - Response: first byte popped at the cycle after its push, so 5 accepted and 1 dropped. q_tx_fifo_full=1, q_overflow=1 and stays 1 after all frames finish.
  - Wire output decodes 01,02,03,04,05.
- Back-to-back:
  - Stimulus: push 8'hFF then 8'h00 on consecutive cycles.
  - Response: second start bit begins exactly 40 cycles after the first start bit; the stop bit is exactly 4 high cycles.
- Push/pop same cycle while full:
  - Stimulus: fill FIFO, then push 8'h77 on the edge the FSM pops.
  - Response: 8'h77 dropped, q_overflow=1, q_count decrements by 1.
- Reset mid-frame:
  - Stimulus: assert i_reset_n low during DATA bit 3 of 8'h3C with 2 bytes queued.
  - Response: q_tx=1 asynchronously, FIFO empty. After release, no further frames are emitted.

Source files
------------

// File: rtl/prco_uart_tx_pkg.sv
// Shared definitions for the PRCO UART transmit path: FSM state encodings,
// default bit divisor and a width helper for the baud counter.
package prco_uart_tx_pkg;

  // Serialiser states; 2-bit encoding shared with the debug port decoder.
  typedef enum logic [1:0] {
    UART_TX_IDLE  = 2'd0,
    UART_TX_START = 2'd1,
    UART_TX_DATA  = 2'd2,
    UART_TX_STOP  = 2'd3
  } uart_tx_state_e;

  // 50 MHz core clock / 115200 baud.
  localparam int PRCO_UART_DIV_115200 = 434;
  localparam int PRCO_UART_FIFO_AW    = 4;
  localparam int UART_DATA_BITS       = 8;

  // Baud counter width; a divisor of 2 still needs one bit.
  function automatic int baud_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/prco_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy counter. Push while full and
// pop while empty are ignored; full/empty are registered from the next count.
// The head word is read combinationally so the consumer can take it on the
// same edge it pops.
module prco_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] q_data,
  output logic [AW:0]      q_count,
  output logic             q_full,
  output logic             q_empty
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered flag, before any same-cycle pop.
  assign push_ok = i_push && !full_reg;
  assign pop_ok  = i_pop && !empty_reg;

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok) begin
      count_next = count_reg + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage write; no reset needed since reset pointers make old data unreachable.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  // Pointers (wrap naturally at DEPTH), occupancy and derived flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign q_data  = mem[rd_ptr_reg];
  assign q_count = count_reg;
  assign q_full  = full_reg;
  assign q_empty = empty_reg;

endmodule

// File: rtl/prco_uart_tx.sv
// UART transmitter for the core's output path: buffers pushed bytes in a
// small FIFO and serialises them as 8N1 frames, LSB first, on q_tx.
// q_tx and q_busy are registered from the current state, so they trail the
// state register by one cycle; reset forces the line high immediately.
module prco_uart_tx
  import prco_uart_tx_pkg::*;
#(
  parameter int CLK_DIV = PRCO_UART_DIV_115200,
  parameter int FIFO_AW = PRCO_UART_FIFO_AW
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_transmit,
  input  logic [7:0]       i_tx_byte,
  output logic             q_tx,
  output logic             q_tx_fifo_full,
  output logic             q_tx_fifo_empty,
  output logic             q_busy,
  output logic [FIFO_AW:0] q_count,
  output logic             q_overflow
);

  localparam int BAUD_W = baud_width(CLK_DIV);

  uart_tx_state_e                 state_reg;
  logic [BAUD_W-1:0]              baud_reg;
  logic [2:0]                     bit_idx_reg;
  logic [UART_DATA_BITS-1:0]      shift_reg;
  logic                           tx_reg;
  logic                           busy_reg;
  logic                           overflow_reg;

  logic [UART_DATA_BITS-1:0]      fifo_data;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           baud_last;

  prco_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (i_transmit),
    .i_data    (i_tx_byte),
    .i_pop     (fifo_pop),
    .q_data    (fifo_data),
    .q_count   (q_count),
    .q_full    (fifo_full),
    .q_empty   (fifo_empty)
  );

  assign baud_last = (baud_reg == BAUD_W'(CLK_DIV - 1));

  // Pop when idle, or at the very end of a stop bit so frames run back to back.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_reg == UART_TX_IDLE) begin
        fifo_pop = 1'b1;
      end else if ((state_reg == UART_TX_STOP) && baud_last) begin
        fifo_pop = 1'b1;
      end
    end
  end

  // Serialiser FSM with baud counter, shift register and registered line/busy.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg   <= UART_TX_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      busy_reg <= (state_reg != UART_TX_IDLE) || !fifo_empty;
      case (state_reg)
        UART_TX_START: tx_reg <= 1'b0;
        UART_TX_DATA:  tx_reg <= shift_reg[0];
        default:       tx_reg <= 1'b1;
      endcase

      case (state_reg)
        UART_TX_IDLE: begin
          if (fifo_pop) begin
            shift_reg <= fifo_data;
            baud_reg  <= '0;
            state_reg <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (baud_last) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            state_reg   <= UART_TX_DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        UART_TX_DATA: begin
          if (baud_last) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= UART_TX_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
        default: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (fifo_pop) begin
              shift_reg <= fifo_data;
              state_reg <= UART_TX_START;
            end else begin
              state_reg <= UART_TX_IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky flag: a push arrived while the FIFO was already full.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_reg <= 1'b0;
    end else if (i_transmit && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

  assign q_tx            = tx_reg;
  assign q_busy          = busy_reg;
  assign q_tx_fifo_full  = fifo_full;
  assign q_tx_fifo_empty = fifo_empty;
  assign q_overflow      = overflow_reg;

endmodule

// File: tb/tb_prco_uart_tx.sv
// Bench for prco_uart_tx with CLK_DIV=4, FIFO_AW=2. Bytes expected on the
// wire are queued when pushed; a line monitor decodes each frame and checks
// it against the queue head.
module tb_prco_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;

  typedef struct packed {
    logic [7:0]       data;
    logic             acc;
    logic [FIFO_AW:0] cnt;
    logic             full;
    logic             empty;
    logic             busy;
    logic             ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_transmit = 1'b0;
  logic [7:0]       i_tx_byte = 8'h00;
  logic             q_tx;
  logic             q_full;
  logic             q_empty;
  logic             q_busy;
  logic [FIFO_AW:0] q_count;
  logic             q_ovf;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  vec_t       vecs[6];

  int         mon_off = 0;
  logic       mon_busy = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] mon_exp;
  logic [7:0] pat;
  logic       etx;
  int         gap;

  prco_uart_tx #(
    .CLK_DIV (CLK_DIV),
    .FIFO_AW (FIFO_AW)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_transmit      (i_transmit),
    .i_tx_byte       (i_tx_byte),
    .q_tx            (q_tx),
    .q_tx_fifo_full  (q_full),
    .q_tx_fifo_empty (q_empty),
    .q_busy          (q_busy),
    .q_count         (q_count),
    .q_overflow      (q_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Line monitor: frame starts at the first low sample; bits sampled mid-period.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
      mon_off  = 0;
    end else if (!mon_busy) begin
      if (q_tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_off  = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_off++;
      if (mon_off == 2) begin
        check("mon_start_bit", q_tx, 0);
      end else if (mon_off >= 6 && mon_off <= 34 && (mon_off % 4) == 2) begin
        mon_byte[(mon_off - 6) / 4] = q_tx;
      end else if (mon_off >= 36) begin
        check("mon_stop_bit", q_tx, 1);
      end
      if (mon_off == 39) begin
        mon_busy = 1'b0;
        $display("frame decoded: %02h at cycle %0d", mon_byte, cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_frame: got byte %02h, required no frame", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_frame", mon_byte, mon_exp);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic accept);
    i_transmit = 1'b1;
    i_tx_byte  = b;
    if (accept) exp_q.push_back(b);
    $display("push %02h expect_accept=%0d at cycle %0d", b, accept, cyc);
    @(negedge clk);
    i_transmit = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_transmit = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("rst_tx", q_tx, 1);
    check("rst_count", q_count, 0);
    check("rst_empty", q_empty, 1);
    check("rst_full", q_full, 0);
    check("rst_busy", q_busy, 0);
    check("rst_ovf", q_ovf, 0);
    rst_n = 1'b1;
    start_q.delete();
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (q_busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, q_busy, 0);
    repeat (2) @(negedge clk);
    check({name, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset and idle
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", q_tx, 1);
      check("idle_empty", q_empty, 1);
      check("idle_busy", q_busy, 0);
      check("idle_count", q_count, 0);
    end

    // Single byte: exact waveform and latency
    do_reset();
    pat = 8'hA5;
    push_byte(8'hA5, 1'b1);
    check("t2_count_n0", q_count, 1);
    check("t2_busy_n0", q_busy, 0);
    check("t2_tx_n0", q_tx, 1);
    @(negedge clk);
    check("t2_count_n1", q_count, 0);
    check("t2_empty_n1", q_empty, 1);
    check("t2_busy_n1", q_busy, 1);
    check("t2_tx_n1", q_tx, 1);
    for (int j = 2; j <= 42; j++) begin
      @(negedge clk);
      if (j <= 5) etx = 1'b0;
      else if (j <= 37) etx = pat[(j - 6) / 4];
      else etx = 1'b1;
      check("t2_tx_wave", q_tx, etx);
      check("t2_busy_wave", q_busy, (j <= 41) ? 1 : 0);
    end
    wait_idle("t2", 100);

    // Fill and overflow, table-driven
    do_reset();
    vecs[0] = '{8'h01, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h04, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h05, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'h06, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      i_transmit = 1'b1;
      i_tx_byte  = vecs[i].data;
      if (vecs[i].acc) exp_q.push_back(vecs[i].data);
      $display("push %02h expect_accept=%0d at cycle %0d", vecs[i].data, vecs[i].acc, cyc);
      @(negedge clk);
      check("t3_count", q_count, vecs[i].cnt);
      check("t3_full", q_full, vecs[i].full);
      check("t3_empty", q_empty, vecs[i].empty);
      check("t3_busy", q_busy, vecs[i].busy);
      check("t3_ovf", q_ovf, vecs[i].ovf);
    end
    i_transmit = 1'b0;
    wait_idle("t3", 400);
    check("t3_ovf_sticky", q_ovf, 1);
    check("t3_end_empty", q_empty, 1);
    check("t3_end_full", q_full, 0);
    check("t3_end_count", q_count, 0);

    // Back-to-back frames
    do_reset();
    push_byte(8'hFF, 1'b1);
    push_byte(8'h00, 1'b1);
    wait_idle("t4", 200);
    check("t4_frames", start_q.size(), 2);
    gap = (start_q.size() >= 2) ? (start_q[1] - start_q[0]) : -1;
    check("t4_start_gap", gap, 40);

    // Push while full on the edge the FSM pops
    do_reset();
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h55, 1'b1);
    check("t5_full_count", q_count, 4);
    check("t5_full_flag", q_full, 1);
    repeat (36) @(negedge clk);
    check("t5_pre_count", q_count, 4);
    check("t5_pre_full", q_full, 1);
    check("t5_pre_ovf", q_ovf, 0);
    push_byte(8'h77, 1'b0);
    check("t5_post_count", q_count, 3);
    check("t5_post_full", q_full, 0);
    check("t5_post_ovf", q_ovf, 1);
    wait_idle("t5", 400);
    check("t5_ovf_sticky", q_ovf, 1);

    // Reset mid-frame during data bit 3 of 8'h3C
    do_reset();
    push_byte(8'h3C, 1'b1);
    push_byte(8'hAA, 1'b1);
    push_byte(8'hBB, 1'b1);
    repeat (17) @(negedge clk);
    check("t6_queued", q_count, 2);
    check("t6_bit3", q_tx, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_async_tx", q_tx, 1);
    check("t6_async_empty", q_empty, 1);
    check("t6_async_count", q_count, 0);
    check("t6_async_busy", q_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_q.delete();
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      check("t6_quiet_tx", q_tx, 1);
    end
    check("t6_no_frames", start_q.size(), 0);
    check("t6_busy", q_busy, 0);
    check("t6_empty", q_empty, 1);
    check("t6_ovf", q_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
